cheri_stkz_lsu_arb: RTL and testbench

Arbiter between the core load/store path and the stack-zeroization engine for the single LSU request port. It grants one requester at a time and holds the grant until the LSU accepts the request. It records the owner of every accepted request in a small in-order tag FIFO and routes each LSU response back to the requester that issued it. It sits between the ID/EX load-store request mux and the LSU, beside the zeroization engine.

---
 rtl/cheri_stkz_lsu_arb.sv | 215 +++++++++++++++++++++
 tb/tb_cheri_stkz_lsu_arb.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cheri_stkz_lsu_arb.sv
// ---------------------------------------------------------------------------
// cheri_stkz_lsu_arb
//
// Shares the single LSU request port between the core load/store path and the
// stack-zeroization engine. One requester is granted at a time. The grant is
// held until the LSU accepts the request. The owner of every accepted request
// is kept in a small in-order tag FIFO, so that each in-order LSU response is
// routed back to the requester that issued it.
//
// Parameters:
//   OUTSTANDING   max accepted-but-unresponded LSU requests (1..4)
//   STARVE_LIMIT  max consecutive core grants while the zeroizer waits
//
// Optional feature macro:
//   CHERI_STKZ_ARB_STARVE_EN  when defined, a zeroizer that has waited through
//                             STARVE_LIMIT core grants wins the next
//                             arbitration. When undefined, the core has
//                             strict priority.
//
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   cpu_req_i / cpu_we_i / cpu_is_cap_i / cpu_addr_i / cpu_wdata_i
//                                    core request
//   stkz_req_i / stkz_addr_i         zeroizer request (always a non-cap
//                                    zero write)
//   lsu_req_o / lsu_we_o / lsu_is_cap_o / lsu_addr_o / lsu_wdata_o
//                                    muxed request to the LSU
//   lsu_req_done_i                   LSU accepted the current request
//   lsu_resp_valid_i, lsu_resp_err_i in-order LSU response
//   cpu_req_done_o, cpu_resp_valid_o, cpu_resp_err_o     routed to the core
//   stkz_req_done_o, stkz_resp_valid_o, stkz_resp_err_o  routed to the zeroizer
//   arb_busy_o                       grant held, or responses outstanding
//   arb_err_o                        sticky: a response arrived with no owner
// ---------------------------------------------------------------------------
module cheri_stkz_lsu_arb #(
    parameter int unsigned OUTSTANDING  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic        cpu_is_cap_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [32:0] cpu_wdata_i,
    input  logic        stkz_req_i,
    input  logic [31:0] stkz_addr_i,
    output logic        lsu_req_o,
    output logic        lsu_we_o,
    output logic        lsu_is_cap_o,
    output logic [31:0] lsu_addr_o,
    output logic [32:0] lsu_wdata_o,
    input  logic        lsu_req_done_i,
    input  logic        lsu_resp_valid_i,
    input  logic        lsu_resp_err_i,
    output logic        cpu_req_done_o,
    output logic        cpu_resp_valid_o,
    output logic        cpu_resp_err_o,
    output logic        stkz_req_done_o,
    output logic        stkz_resp_valid_o,
    output logic        stkz_resp_err_o,
    output logic        arb_busy_o,
    output logic        arb_err_o
);

    localparam int unsigned      PTR_W    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned      CNT_W    = $clog2(OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_CPU,
        ARB_STKZ
    } arb_state_e;

    arb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic             owner_q [OUTSTANDING];  // 0 = cpu, 1 = stkz
    logic             err_q;

    logic fifo_empty, fifo_full, starve_fire;
    logic gnt_cpu, gnt_stkz, accept, pop, head_owner;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign fifo_empty = (cnt_q == '0);
    // A response in the same cycle frees the head slot. This lets a grant
    // resume without a bubble. The push then lands in the slot being popped.
    assign fifo_full  = (cnt_q == CNT_FULL) && !lsu_resp_valid_i;

    // ---------------------------------------------------------------- grant
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        gnt_cpu  = 1'b0;
        gnt_stkz = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (!fifo_full) begin
                    if (stkz_req_i && (!cpu_req_i || starve_fire)) gnt_stkz = 1'b1;
                    else if (cpu_req_i)                            gnt_cpu  = 1'b1;
                end
            end
            ARB_CPU:  gnt_cpu  = 1'b1;
            ARB_STKZ: gnt_stkz = 1'b1;
            default: ;
        endcase
    end

    // A locked requester that drops its req withdraws the request.
    assign lsu_req_o       = (gnt_cpu & cpu_req_i) | (gnt_stkz & stkz_req_i);
    assign accept          = lsu_req_o & lsu_req_done_i;
    assign cpu_req_done_o  = accept & gnt_cpu;
    assign stkz_req_done_o = accept & gnt_stkz;

    always_comb begin
        lsu_we_o     = 1'b0;
        lsu_is_cap_o = 1'b0;
        lsu_addr_o   = '0;
        lsu_wdata_o  = '0;
        if (gnt_stkz) begin
            lsu_we_o   = 1'b1;
            lsu_addr_o = stkz_addr_i;
        end else if (gnt_cpu) begin
            lsu_we_o     = cpu_we_i;
            lsu_is_cap_o = cpu_is_cap_i;
            lsu_addr_o   = cpu_addr_i;
            lsu_wdata_o  = cpu_wdata_i;
        end
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state is updated with non-blocking assignments, so every
        // flop samples the values from before the edge.
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (lsu_req_o && !lsu_req_done_i)
                        state_q <= gnt_stkz ? ARB_STKZ : ARB_CPU;
                end
                ARB_CPU, ARB_STKZ: begin
                    if (!lsu_req_o || lsu_req_done_i) state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------- owner FIFO
    assign pop        = lsu_resp_valid_i & !fifo_empty;
    assign head_owner = owner_q[rptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) wptr_q <= ptr_inc(wptr_q);
            if (pop)    rptr_q <= ptr_inc(rptr_q);
            unique case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
            if (lsu_resp_valid_i && fifo_empty) err_q <= 1'b1;
        end
    end

    // NOTE: the tag storage has no reset. An entry is only read while the
    // count marks it valid, and the count and pointers are reset.
    always_ff @(posedge clk_i) begin
        if (accept) owner_q[wptr_q] <= gnt_stkz;
    end

    // ---------------------------------------------------- starvation guard
`ifdef CHERI_STKZ_ARB_STARVE_EN
    localparam int unsigned SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    logic [SC_W-1:0] starve_cnt_q;

    assign starve_fire = (starve_cnt_q == SC_W'(STARVE_LIMIT));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
        end else if (!stkz_req_i || gnt_stkz) begin
            starve_cnt_q <= '0;
        end else if (cpu_req_done_o && !starve_fire) begin
            starve_cnt_q <= starve_cnt_q + 1'b1;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign starve_fire         = 1'b0;
`endif

    // -------------------------------------------------------------- routing
    assign cpu_resp_valid_o  = pop & !head_owner;
    assign cpu_resp_err_o    = pop & !head_owner & lsu_resp_err_i;
    assign stkz_resp_valid_o = pop & head_owner;
    assign stkz_resp_err_o   = pop & head_owner & lsu_resp_err_i;

    assign arb_busy_o = (state_q != ARB_IDLE) || !fifo_empty;
    assign arb_err_o  = err_q;

endmodule

// File: tb/tb_cheri_stkz_lsu_arb.sv
// ---------------------------------------------------------------------------
// tb_cheri_stkz_lsu_arb
//
// Scoreboard bench for cheri_stkz_lsu_arb with default parameters
// (OUTSTANDING=2, STARVE_LIMIT=4). The stimulus pushes each hand-computed
// accepted request and each routed response into queues. A monitor on the
// falling edge pops an entry and compares it whenever the DUT accepts a
// request or a response arrives. Direct checks cover the cases where no
// output event should occur (FIFO full, grant lock, sticky error).
// ---------------------------------------------------------------------------
module tb_cheri_stkz_lsu_arb;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cpu_req_i, cpu_we_i, cpu_is_cap_i;
    logic [31:0] cpu_addr_i;
    logic [32:0] cpu_wdata_i;
    logic        stkz_req_i;
    logic [31:0] stkz_addr_i;
    logic        lsu_req_o, lsu_we_o, lsu_is_cap_o;
    logic [31:0] lsu_addr_o;
    logic [32:0] lsu_wdata_o;
    logic        lsu_req_done_i, lsu_resp_valid_i, lsu_resp_err_i;
    logic        cpu_req_done_o, cpu_resp_valid_o, cpu_resp_err_o;
    logic        stkz_req_done_o, stkz_resp_valid_o, stkz_resp_err_o;
    logic        arb_busy_o, arb_err_o;

    cheri_stkz_lsu_arb dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .cpu_req_i         (cpu_req_i),
        .cpu_we_i          (cpu_we_i),
        .cpu_is_cap_i      (cpu_is_cap_i),
        .cpu_addr_i        (cpu_addr_i),
        .cpu_wdata_i       (cpu_wdata_i),
        .stkz_req_i        (stkz_req_i),
        .stkz_addr_i       (stkz_addr_i),
        .lsu_req_o         (lsu_req_o),
        .lsu_we_o          (lsu_we_o),
        .lsu_is_cap_o      (lsu_is_cap_o),
        .lsu_addr_o        (lsu_addr_o),
        .lsu_wdata_o       (lsu_wdata_o),
        .lsu_req_done_i    (lsu_req_done_i),
        .lsu_resp_valid_i  (lsu_resp_valid_i),
        .lsu_resp_err_i    (lsu_resp_err_i),
        .cpu_req_done_o    (cpu_req_done_o),
        .cpu_resp_valid_o  (cpu_resp_valid_o),
        .cpu_resp_err_o    (cpu_resp_err_o),
        .stkz_req_done_o   (stkz_req_done_o),
        .stkz_resp_valid_o (stkz_resp_valid_o),
        .stkz_resp_err_o   (stkz_resp_err_o),
        .arb_busy_o        (arb_busy_o),
        .arb_err_o         (arb_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        owner;  // 0 = cpu, 1 = stkz
        logic [31:0] addr;
        logic        we;
        logic        cap;
        logic [32:0] wdata;
    } req_t;

    req_t       req_q[$];
    logic [3:0] rsp_q[$];  // {cpu_valid, cpu_err, stkz_valid, stkz_err}

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] STKZ_A0 = 32'h8000_0FFC;
    localparam logic [31:0] STKZ_A1 = 32'h8000_0F00;
    localparam logic [31:0] STKZ_A2 = 32'h8000_0100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_req(input logic owner, input logic [31:0] addr, input logic we,
                            input logic cap, input logic [32:0] wdata);
        req_t r;
        r.owner = owner;
        r.addr  = addr;
        r.we    = we;
        r.cap   = cap;
        r.wdata = wdata;
        req_q.push_back(r);
    endtask

    task automatic push_rsp(input logic [3:0] v);
        rsp_q.push_back(v);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_req_i        = 1'b0;
        cpu_we_i         = 1'b0;
        cpu_is_cap_i     = 1'b0;
        cpu_addr_i       = '0;
        cpu_wdata_i      = '0;
        stkz_req_i       = 1'b0;
        stkz_addr_i      = '0;
        lsu_req_done_i   = 1'b0;
        lsu_resp_valid_i = 1'b0;
        lsu_resp_err_i   = 1'b0;
    endtask

    // ------------------------------------------------------------- monitor
    always @(negedge clk) begin
        req_t e;
        logic [3:0] r;
        if (rst_ni) begin
            if ((lsu_req_o && lsu_req_done_i) || cpu_req_done_o || stkz_req_done_o) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected: got accepted request addr %0h, expected none at %0t",
                             lsu_addr_o, $time);
                end else begin
                    e = req_q.pop_front();
                    check("req_done_route", {cpu_req_done_o, stkz_req_done_o}, {~e.owner, e.owner});
                    check("req_addr",  lsu_addr_o,   e.addr);
                    check("req_we",    lsu_we_o,     e.we);
                    check("req_cap",   lsu_is_cap_o, e.cap);
                    check("req_wdata", lsu_wdata_o,  e.wdata);
                end
            end
            if (lsu_resp_valid_i || cpu_resp_valid_o || stkz_resp_valid_o) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got response event, expected none at %0t", $time);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_route", {cpu_resp_valid_o, cpu_resp_err_o,
                                        stkz_resp_valid_o, stkz_resp_err_o}, r);
                end
            end
        end
    end

    // ------------------------------------------------------------ watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [31:0] a;
        logic [32:0] wd;
        logic        own, prev_own;

        clear_inputs();
        rst_ni = 1'b0;
        #2;
        check("rst_lsu_req", lsu_req_o, 1'b0);
        check("rst_outputs", {lsu_we_o, lsu_is_cap_o, lsu_addr_o, lsu_wdata_o,
                              cpu_req_done_o, cpu_resp_valid_o, cpu_resp_err_o,
                              stkz_req_done_o, stkz_resp_valid_o, stkz_resp_err_o,
                              arb_busy_o, arb_err_o}, '0);
        @(negedge clk);
        rst_ni = 1'b1;
        cycle();

        // Zeroizer alone: accepted one cycle after request, response two
        // cycles after acceptance.
        stkz_req_i  = 1'b1;
        stkz_addr_i = STKZ_A0;
        #2;
        check("stkz_req",   lsu_req_o,    1'b1);
        check("stkz_we",    lsu_we_o,     1'b1);
        check("stkz_cap",   lsu_is_cap_o, 1'b0);
        check("stkz_wdata", lsu_wdata_o,  33'h0);
        cycle();
        lsu_req_done_i = 1'b1;
        push_req(1'b1, STKZ_A0, 1'b1, 1'b0, 33'h0);
        cycle();
        stkz_req_i     = 1'b0;
        lsu_req_done_i = 1'b0;
        cycle();
        lsu_resp_valid_i = 1'b1;
        push_rsp(4'b0010);
        cycle();
        lsu_resp_valid_i = 1'b0;
        #2;
        check("stkz_idle_busy", arb_busy_o, 1'b0);

`ifndef CHERI_STKZ_ARB_STARVE_EN
        // Strict priority: the core wins while it requests. The zeroizer is
        // served in the first cycle the core is quiet. Each response arrives
        // the cycle after its acceptance, so push and pop overlap.
        for (int i = 0; i < 4; i++) begin
            a  = 32'h1000_0000 + 32'(i * 4);
            wd = {1'b1, 32'hA5A5_0000 + 32'(i)};
            cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_is_cap_i = 1'b1;
            cpu_addr_i = a;   cpu_wdata_i = wd;
            stkz_req_i = 1'b1; stkz_addr_i = STKZ_A1;
            lsu_req_done_i   = 1'b1;
            lsu_resp_valid_i = (i > 0);
            push_req(1'b0, a, 1'b0, 1'b1, wd);
            if (i > 0) push_rsp(4'b1000);
            cycle();
        end
        cpu_req_i        = 1'b0;
        lsu_resp_valid_i = 1'b1;
        push_req(1'b1, STKZ_A1, 1'b1, 1'b0, 33'h0);
        push_rsp(4'b1000);
        cycle();
        stkz_req_i     = 1'b0;
        lsu_req_done_i = 1'b0;
        push_rsp(4'b0010);
        cycle();
        lsu_resp_valid_i = 1'b0;
`else
        // Starvation guard: both requesting with done every cycle gives the
        // pattern cpu x4, stkz, repeating.
        prev_own = 1'b0;
        for (int i = 0; i < 10; i++) begin
            own = ((i % 5) == 4);
            a   = 32'h1000_0000 + 32'(i * 4);
            wd  = {1'b1, 32'hA5A5_0000 + 32'(i)};
            cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_is_cap_i = 1'b1;
            cpu_addr_i = a;   cpu_wdata_i = wd;
            stkz_req_i = 1'b1; stkz_addr_i = STKZ_A1;
            lsu_req_done_i   = 1'b1;
            lsu_resp_valid_i = (i > 0);
            if (own) push_req(1'b1, STKZ_A1, 1'b1, 1'b0, 33'h0);
            else     push_req(1'b0, a, 1'b0, 1'b1, wd);
            if (i > 0) push_rsp(prev_own ? 4'b0010 : 4'b1000);
            prev_own = own;
            cycle();
        end
        cpu_req_i        = 1'b0;
        stkz_req_i       = 1'b0;
        lsu_req_done_i   = 1'b0;
        lsu_resp_valid_i = 1'b1;
        push_rsp(prev_own ? 4'b0010 : 4'b1000);
        cycle();
        lsu_resp_valid_i = 1'b0;
`endif

        // Grant lock: the zeroizer holds the port for 3 cycles while the core
        // waits. The core is served the cycle after the zeroizer's done.
        clear_inputs();
        stkz_req_i  = 1'b1;
        stkz_addr_i = STKZ_A2;
        #2;
        check("lock_c0_addr", lsu_addr_o, STKZ_A2);
        cycle();
        cpu_req_i   = 1'b1;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = 32'h1234_5678;
        cpu_wdata_i = 33'h0_DEAD_BEEF;
        #2;
        check("lock_c1_addr", lsu_addr_o, STKZ_A2);
        check("lock_c1_we",   lsu_we_o,   1'b1);
        cycle();
        #2;
        check("lock_c2_addr", lsu_addr_o, STKZ_A2);
        cycle();
        lsu_req_done_i = 1'b1;
        push_req(1'b1, STKZ_A2, 1'b1, 1'b0, 33'h0);
        cycle();
        stkz_req_i       = 1'b0;
        lsu_resp_valid_i = 1'b1;
        push_req(1'b0, 32'h1234_5678, 1'b0, 1'b0, 33'h0_DEAD_BEEF);
        push_rsp(4'b0010);
        #2;
        check("lock_cpu_next", lsu_addr_o, 32'h1234_5678);
        cycle();
        cpu_req_i      = 1'b0;
        lsu_req_done_i = 1'b0;
        push_rsp(4'b1000);
        cycle();
        lsu_resp_valid_i = 1'b0;

        // FIFO full: two accepted requests (stkz, then cpu) with no response
        // block the third. An error response frees a slot and the grant
        // resumes in the same cycle.
        clear_inputs();
        stkz_req_i     = 1'b1;
        stkz_addr_i    = STKZ_A0;
        lsu_req_done_i = 1'b1;
        push_req(1'b1, STKZ_A0, 1'b1, 1'b0, 33'h0);
        cycle();
        stkz_req_i  = 1'b0;
        cpu_req_i   = 1'b1;
        cpu_we_i    = 1'b1;
        cpu_addr_i  = 32'h0000_2000;
        cpu_wdata_i = 33'h1_0000_0001;
        push_req(1'b0, 32'h0000_2000, 1'b1, 1'b0, 33'h1_0000_0001);
        cycle();
        cpu_addr_i     = 32'h0000_2004;
        cpu_wdata_i    = 33'h0_0000_0002;
        lsu_req_done_i = 1'b0;
        #2;
        check("full_no_req", lsu_req_o,  1'b0);
        check("full_busy",   arb_busy_o, 1'b1);
        cycle();
        lsu_req_done_i   = 1'b1;
        lsu_resp_valid_i = 1'b1;
        lsu_resp_err_i   = 1'b1;
        push_rsp(4'b0011);
        push_req(1'b0, 32'h0000_2004, 1'b1, 1'b0, 33'h0_0000_0002);
        #2;
        check("full_resume_req", lsu_req_o, 1'b1);
        cycle();
        cpu_req_i      = 1'b0;
        lsu_req_done_i = 1'b0;
        lsu_resp_err_i = 1'b0;
        push_rsp(4'b1000);
        cycle();
        lsu_resp_err_i = 1'b1;
        push_rsp(4'b1100);
        cycle();
        clear_inputs();
        #2;
        check("full_drained_busy", arb_busy_o, 1'b0);

        // Abandoned request: the core drops its req while locked. Nothing is
        // pushed, so the following response finds the FIFO empty.
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h0000_3000;
        #2;
        check("abandon_req", lsu_req_o, 1'b1);
        cycle();
        cpu_req_i = 1'b0;
        #2;
        check("abandon_drop", lsu_req_o,  1'b0);
        check("abandon_lock", arb_busy_o, 1'b1);
        cycle();
        #2;
        check("abandon_idle", arb_busy_o, 1'b0);

        // Pop while empty: nothing is routed and the sticky error sets.
        lsu_resp_valid_i = 1'b1;
        lsu_resp_err_i   = 1'b1;
        push_rsp(4'b0000);
        cycle();
        clear_inputs();
        #2;
        check("err_set", arb_err_o, 1'b1);
        cycle();
        cycle();
        cycle();
        check("err_sticky", arb_err_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        check("err_reset", arb_err_o, 1'b0);

        check("req_q_drained", req_q.size(), 0);
        check("rsp_q_drained", rsp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
